full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered, parameterizable-width ripple-carry adder built from a chain of 1-bit full-adder cells.
- Computes sum = a + b + cin and a carry-out, captured into output registers with a valid qualifier.
- Sits in datapath arithmetic as the shared add primitive.
- WIDTH=1 is the classic single-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/carry hold a freshly computed result.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out of the MSB cell.

Behaviour:
- Each cell i computes s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]), with c[0] = cin.
- The carry chain ripples combinationally from bit 0 to bit WIDTH-1. {carry, sum} equals a + b + cin exactly (WIDTH+1-bit result, no truncation).
- Reset:
  - rst high asynchronously forces sum=0, carry=0, out_valid=0, regardless of clk.
  - Outputs stay 0 while rst is held.
  - The first capture occurs on the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle. Operands sampled at rising edge N appear on sum/carry after edge N, with out_valid=1.
- Capture control:
  - in_valid=1 at an edge: sum/carry load the new result; out_valid<=1.
  - in_valid=0 at an edge: sum/carry hold their previous values; out_valid<=0.
- No backpressure: one result per cycle, full throughput; back-to-back in_valid is legal.
- Boundary cases:
  - All-ones a and b with cin=1 gives sum = all-ones and carry=1.
  - All-zeros with cin=0 gives 0/0.
  - Wrap-around is expressed only through carry.
- Reset mid-operation discards any pending result; out_valid drops immediately (asynchronously).
- X on a/b/cin while in_valid=0 must not propagate into the held outputs.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit, registered alongside sum).
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow. For WIDTH=1, c[0] is cin.
  - ovf follows the same reset (0), hold, and latency rules as carry.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1 exhaustive: drive all 8 (a,b,cin) combinations with in_valid=1, one per cycle. One cycle later sum/carry must be:
  - 000 -> 0/0
  - 001 -> 1/0
  - 010 -> 1/0
  - 011 -> 0/1
  - 100 -> 1/0
  - 101 -> 0/1
  - 110 -> 0/1
  - 111 -> 1/1
- Async reset: after a result of 1/1, assert rst between clock edges. sum=0, carry=0 and out_valid=0 immediately, without waiting for a clk edge.
- Hold: apply a=1,b=0,cin=1 with in_valid=1, then in_valid=0 with a=0,b=0,cin=0 for 3 cycles. sum/carry stay 0/1 and out_valid=0 for those cycles.
- WIDTH=8 boundary:
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
  - a=0x80, b=0x80, cin=0 -> sum=0x00, carry=1.
- Back-to-back WIDTH=8: a=0x0F,b=0x01,cin=0 then a=0x10,b=0x20,cin=1 on consecutive edges -> sum 0x10 then 0x31, out_valid high both cycles.
- With FULL_ADDER_OVERFLOW_EN, WIDTH=8:
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0, ovf=1.
  - a=0xFF, b=0x01, cin=0 -> ovf=0, carry=1.

Source files
------------

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The ovf signal exists only when FULL_ADDER_OVERFLOW_EN is defined.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, carry, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, carry
  );
`endif
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} = a+b+cin, 1-cycle latency.
// Optional signed-overflow output ovf enabled by FULL_ADDER_OVERFLOW_EN.
module full_adder #(
  parameter int WIDTH = 1
) (
  input logic       clk,
  input logic       rst,
  full_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;
  logic             msb_cin;
  logic             valid_q;

  // Scalar running carry keeps the chain free of vector self-loops.
  always_comb begin : ripple
    logic cy;
    cy      = bus.cin;
    msb_cin = bus.cin;
    sum_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      msb_cin  = cy;
      sum_d[i] = bus.a[i] ^ bus.b[i] ^ cy;
      cy       = (bus.a[i] & bus.b[i])
               | (bus.a[i] & cy)
               | (bus.b[i] & cy);
    end
    carry_d = cy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = carry_d ^ msb_cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=8: directed literals plus
// randomized traffic checked every cycle against an arithmetic model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) f1 ();
  full_adder_if #(.WIDTH(8)) f8 ();

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk),
    .rst(rst),
    .bus(f1)
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk),
    .rst(rst),
    .bus(f8)
  );

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Signed overflow from value ranges, not from carries.
  function automatic bit sovf(input longint a,
                              input longint b,
                              input longint c,
                              input int w);
    longint sa, sb, t, lo, hi;
    lo = -(longint'(1) <<< (w - 1));
    hi = (longint'(1) <<< (w - 1)) - 1;
    sa = (a > hi) ? a - (longint'(1) <<< w) : a;
    sb = (b > hi) ? b - (longint'(1) <<< w) : b;
    t  = sa + sb + c;
    return (t > hi) || (t < lo);
  endfunction

  // Reference model
  bit           m1_v, m1_c, m1_o;
  bit           m1_s;
  bit           m8_v, m8_c, m8_o;
  bit [7:0]     m8_s;

  always @(posedge clk or posedge rst) begin
    longint t;
    if (rst) begin
      m1_v = 0; m1_c = 0; m1_s = 0; m1_o = 0;
      m8_v = 0; m8_c = 0; m8_s = 0; m8_o = 0;
    end else begin
      m1_v = f1.in_valid;
      if (f1.in_valid) begin
        t    = longint'(f1.a) + longint'(f1.b)
             + longint'(f1.cin);
        m1_s = t[0];
        m1_c = t[1];
        m1_o = sovf(longint'(f1.a), longint'(f1.b),
                    longint'(f1.cin), 1);
      end
      m8_v = f8.in_valid;
      if (f8.in_valid) begin
        t    = longint'(f8.a) + longint'(f8.b)
             + longint'(f8.cin);
        m8_s = t[7:0];
        m8_c = t[8];
        m8_o = sovf(longint'(f8.a), longint'(f8.b),
                    longint'(f8.cin), 8);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m1_valid", longint'(f1.out_valid), longint'(m1_v));
      check("m1_sum",   longint'(f1.sum),       longint'(m1_s));
      check("m1_carry", longint'(f1.carry),     longint'(m1_c));
      check("m8_valid", longint'(f8.out_valid), longint'(m8_v));
      check("m8_sum",   longint'(f8.sum),       longint'(m8_s));
      check("m8_carry", longint'(f8.carry),     longint'(m8_c));
`ifdef FULL_ADDER_OVERFLOW_EN
      check("m1_ovf", longint'(f1.ovf), longint'(m1_o));
      check("m8_ovf", longint'(f8.ovf), longint'(m8_o));
`endif
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input bit v, input bit a,
                      input bit b, input bit c);
    f1.in_valid = v; f1.a = a; f1.b = b; f1.cin = c;
  endtask

  task automatic drv8(input bit v, input bit [7:0] a,
                      input bit [7:0] b, input bit c);
    f8.in_valid = v; f8.a = a; f8.b = b; f8.cin = c;
  endtask

  task automatic chk8(input string nm, input bit [7:0] s,
                      input bit c, input bit v);
    check({nm, "_sum"},   longint'(f8.sum),       longint'(s));
    check({nm, "_carry"}, longint'(f8.carry),     longint'(c));
    check({nm, "_valid"}, longint'(f8.out_valid), longint'(v));
  endtask

  int exp1 [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

  initial begin
    rst = 1'b1;
    drv1(0, 0, 0, 0);
    drv8(0, 8'h00, 8'h00, 0);
    #1;
    check("rst_sum8",   longint'(f8.sum),       0);
    check("rst_valid8", longint'(f8.out_valid), 0);
    edge1();
    chk_en = 1'b1;
    edge1();
    check("rst_hold_sum1", longint'(f1.sum), 0);
    rst = 1'b0;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      drv1(1, i[2], i[1], i[0]);
      edge1();
      check($sformatf("tt%0d_sc", i),
            longint'({f1.carry, f1.sum}), longint'(exp1[i]));
      check($sformatf("tt%0d_v", i),
            longint'(f1.out_valid), 1);
    end

    // async reset between edges
    #3;
    rst = 1'b1;
    #1;
    check("arst_sum",   longint'(f1.sum),       0);
    check("arst_carry", longint'(f1.carry),     0);
    check("arst_valid", longint'(f1.out_valid), 0);
    drv1(0, 0, 0, 0);
    edge1();
    #1;
    rst = 1'b0;
    edge1();

    // hold
    drv1(1, 1, 0, 1);
    edge1();
    check("hold0_sc", longint'({f1.carry, f1.sum}), 2);
    check("hold0_v",  longint'(f1.out_valid), 1);
    drv1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      edge1();
      check($sformatf("hold%0d_sc", i + 1),
            longint'({f1.carry, f1.sum}), 2);
      check($sformatf("hold%0d_v", i + 1),
            longint'(f1.out_valid), 0);
    end

    // WIDTH=8 boundaries and back-to-back
    drv8(1, 8'hFF, 8'hFF, 1);
    edge1();
    chk8("ones", 8'hFF, 1, 1);
    drv8(1, 8'h80, 8'h80, 0);
    edge1();
    chk8("msb", 8'h00, 1, 1);
    drv8(1, 8'h00, 8'h00, 0);
    edge1();
    chk8("zero", 8'h00, 0, 1);
    drv8(1, 8'h0F, 8'h01, 0);
    edge1();
    chk8("b2b0", 8'h10, 0, 1);
    drv8(1, 8'h10, 8'h20, 1);
    edge1();
    chk8("b2b1", 8'h31, 0, 1);
`ifdef FULL_ADDER_OVERFLOW_EN
    drv8(1, 8'h7F, 8'h01, 0);
    edge1();
    chk8("ovf1", 8'h80, 0, 1);
    check("ovf1_ovf", longint'(f8.ovf), 1);
    drv8(1, 8'hFF, 8'h01, 0);
    edge1();
    chk8("ovf0", 8'h00, 1, 1);
    check("ovf0_ovf", longint'(f8.ovf), 0);
`endif
    drv8(0, 8'h00, 8'h00, 0);
    edge1();

    // randomized traffic, model checks every negedge
    for (int n = 0; n < 400; n++) begin
      drv1(1'($urandom_range(0, 1)), 1'($urandom),
           1'($urandom), 1'($urandom));
      drv8(1'($urandom_range(0, 3) != 0), 8'($urandom),
           8'($urandom), 1'($urandom));
      if ($urandom_range(0, 40) == 0) begin
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      edge1();
    end

    drv1(0, 0, 0, 0);
    drv8(0, 8'h00, 8'h00, 0);
    edge1();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
